// File: rtl/hazard_tracker_if.sv
// hazard_tracker_if
//   Bundles the ID-stage request and the tracker's tag/hazard response.
//   master : pipeline control side (drives ID info, reads tags/hazard)
//   slave  : hazard_tracker itself
//   Control : freeze, flush, fwd_en
//   ID      : ID_valid, ID_Dest, ID_WB_en, ID_MEM_R_en, src1, src2, two_src
//   Tags    : {EXE,MEM,WB}_Dest, {EXE,MEM,WB}_WB_en
//   Status  : hazard, stall_cnt
interface hazard_tracker_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             freeze;
    logic             flush;
    logic             fwd_en;
    logic             ID_valid;
    logic [REG_W-1:0] ID_Dest;
    logic             ID_WB_en;
    logic             ID_MEM_R_en;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
    logic [REG_W-1:0] EXE_Dest;
    logic [REG_W-1:0] MEM_Dest;
    logic [REG_W-1:0] WB_Dest;
    logic             EXE_WB_en;
    logic             MEM_WB_en;
    logic             WB_WB_en;
    logic             hazard;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output freeze, flush, fwd_en, ID_valid, ID_Dest, ID_WB_en, ID_MEM_R_en,
               src1, src2, two_src,
        input  EXE_Dest, MEM_Dest, WB_Dest, EXE_WB_en, MEM_WB_en, WB_WB_en,
               hazard, stall_cnt
    );

    modport slave (
        input  freeze, flush, fwd_en, ID_valid, ID_Dest, ID_WB_en, ID_MEM_R_en,
               src1, src2, two_src,
        output EXE_Dest, MEM_Dest, WB_Dest, EXE_WB_en, MEM_WB_en, WB_WB_en,
               hazard, stall_cnt
    );
endinterface

// File: rtl/hazard_tracker.sv
// hazard_tracker
//   Producer side of operand forwarding. Carries the destination tag of each
//   in-flight instruction through EXE, MEM and WB, and flags when ID must
//   stall because forwarding cannot supply an operand (load-use, or any RAW
//   on EXE/MEM when forwarding is off). Counts stall cycles, saturating.
//   clk   : pipeline clock
//   rst_n : synchronous active-low reset
//   bus   : hazard_tracker_if.slave (control, ID info, tags, hazard, counter)
//   REG_W/CNT_W must match the parameters of the connected interface.
module hazard_tracker #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_tracker_if.slave    bus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_r_en;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t           exe_q, mem_q, wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hazard;

    // A stage can only supply a match if it is live and actually writes.
    logic e_m1, e_m2, m_m1, m_m2;
    always_comb begin
        e_m1 = exe_q.valid & exe_q.wb_en & (bus.src1 == exe_q.dest);
        e_m2 = bus.two_src & exe_q.valid & exe_q.wb_en & (bus.src2 == exe_q.dest);
        m_m1 = mem_q.valid & mem_q.wb_en & (bus.src1 == mem_q.dest);
        m_m2 = bus.two_src & mem_q.valid & mem_q.wb_en & (bus.src2 == mem_q.dest);
    end

    // WB never stalls: the register file is written before ID reads it.
    always_comb begin
        hazard = 1'b0;
        if (bus.ID_valid && !bus.flush) begin
            if (bus.fwd_en)
                hazard = exe_q.mem_r_en & (e_m1 | e_m2);
            else
                hazard = e_m1 | e_m2 | m_m1 | m_m2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exe_q       <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            stall_cnt_q <= '0;
        end else if (!bus.freeze) begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            if (hazard || bus.flush || !bus.ID_valid)
                exe_q <= BUBBLE;
            else
                exe_q <= '{valid: 1'b1, dest: bus.ID_Dest,
                           wb_en: bus.ID_WB_en, mem_r_en: bus.ID_MEM_R_en};
            if (hazard && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Bubbles are stored with dest=0, so the raw tag already reads 0 when idle.
    assign bus.EXE_Dest  = exe_q.dest;
    assign bus.MEM_Dest  = mem_q.dest;
    assign bus.WB_Dest   = wb_q.dest;
    assign bus.EXE_WB_en = exe_q.valid & exe_q.wb_en;
    assign bus.MEM_WB_en = mem_q.valid & mem_q.wb_en;
    assign bus.WB_WB_en  = wb_q.valid & wb_q.wb_en;
    assign bus.hazard    = hazard;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
module tb_hazard_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_tracker_if #(.REG_W(4), .CNT_W(16)) hif ();
    hazard_tracker_if #(.REG_W(4), .CNT_W(4))  sif ();

    hazard_tracker #(.REG_W(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(hif));
    // Narrow-counter instance so saturation is reachable in a few cycles.
    hazard_tracker #(.REG_W(4), .CNT_W(4))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(sif));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, input int dest, input logic wb, input logic ld,
                      input int s1, input int s2, input logic two);
        hif.ID_valid    = v;
        hif.ID_Dest     = 4'(dest);
        hif.ID_WB_en    = wb;
        hif.ID_MEM_R_en = ld;
        hif.src1        = 4'(s1);
        hif.src2        = 4'(s2);
        hif.two_src     = two;
        #1;
    endtask

    task automatic drain();
        id(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        hif.freeze = 0; hif.flush = 0; hif.fwd_en = 1;
        sif.freeze = 0; sif.flush = 0; sif.fwd_en = 0;
        sif.ID_valid = 0; sif.ID_Dest = 0; sif.ID_WB_en = 0; sif.ID_MEM_R_en = 0;
        sif.src1 = 0; sif.src2 = 0; sif.two_src = 0;

        // Reset with a live ID instruction present
        id(1, 9, 1, 0, 0, 0, 0);
        rst_n = 0;
        step(); step();
        chk("rst_exe_wb", int'(hif.EXE_WB_en), 0);
        chk("rst_mem_wb", int'(hif.MEM_WB_en), 0);
        chk("rst_wb_wb", int'(hif.WB_WB_en), 0);
        chk("rst_dests", int'({hif.EXE_Dest, hif.MEM_Dest, hif.WB_Dest}), 0);
        chk("rst_cnt", int'(hif.stall_cnt), 0);
        chk("rst_hazard", int'(hif.hazard), 0);
        id(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1;
        step();

        // Tag pipeline: ALU dest=3
        id(1, 3, 1, 0, 0, 0, 0);
        step();
        id(0, 0, 0, 0, 0, 0, 0);
        chk("pipe_exe_dest", int'(hif.EXE_Dest), 3);
        chk("pipe_exe_wb", int'(hif.EXE_WB_en), 1);
        step();
        chk("pipe_mem_dest", int'(hif.MEM_Dest), 3);
        chk("pipe_mem_wb", int'(hif.MEM_WB_en), 1);
        chk("pipe_exe_empty", int'(hif.EXE_WB_en), 0);
        step();
        chk("pipe_wb_dest", int'(hif.WB_Dest), 3);
        chk("pipe_wb_wb", int'(hif.WB_WB_en), 1);
        step();
        chk("pipe_all_empty", int'({hif.EXE_WB_en, hif.MEM_WB_en, hif.WB_WB_en}), 0);
        chk("pipe_wb_dest0", int'(hif.WB_Dest), 0);

        // Load-use with forwarding
        hif.fwd_en = 1;
        id(1, 5, 1, 1, 0, 0, 0);
        step();
        id(1, 6, 1, 0, 5, 0, 0);
        chk("lu_hazard", int'(hif.hazard), 1);
        step();
        chk("lu_exe_bubble", int'(hif.EXE_WB_en), 0);
        chk("lu_exe_dest0", int'(hif.EXE_Dest), 0);
        chk("lu_mem_dest", int'(hif.MEM_Dest), 5);
        chk("lu_cnt", int'(hif.stall_cnt), 1);
        chk("lu_hazard_drop", int'(hif.hazard), 0);
        step();
        chk("lu_dep_in_exe", int'(hif.EXE_Dest), 6);
        chk("lu_dep_wb", int'(hif.EXE_WB_en), 1);
        drain();

        // No forwarding, two-source RAW on src2
        hif.fwd_en = 0;
        id(1, 2, 1, 0, 0, 0, 0);
        step();
        id(1, 4, 1, 0, 0, 2, 1);
        chk("nf_hazard_exe", int'(hif.hazard), 1);
        step();
        chk("nf_hazard_mem", int'(hif.hazard), 1);
        chk("nf_cnt1", int'(hif.stall_cnt), 2);
        step();
        chk("nf_hazard_wb", int'(hif.hazard), 0);
        chk("nf_cnt2", int'(hif.stall_cnt), 3);
        drain();
        // Same dependency through src2 but two_src=0: no stall
        id(1, 2, 1, 0, 0, 0, 0);
        step();
        id(1, 4, 1, 0, 0, 2, 0);
        chk("nf_one_src", int'(hif.hazard), 0);
        drain();

        // Freeze holds everything while the hazard persists
        hif.fwd_en = 1;
        id(1, 7, 1, 1, 0, 0, 0);
        step();
        id(1, 8, 1, 0, 7, 0, 0);
        hif.freeze = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("frz_exe_dest", int'(hif.EXE_Dest), 7);
            chk("frz_hazard", int'(hif.hazard), 1);
            chk("frz_cnt", int'(hif.stall_cnt), 3);
        end
        hif.freeze = 0;
        step();
        chk("frz_rel_cnt", int'(hif.stall_cnt), 4);
        chk("frz_rel_mem", int'(hif.MEM_Dest), 7);
        chk("frz_rel_hazard", int'(hif.hazard), 0);
        drain();

        // Flush beats hazard
        id(1, 10, 1, 1, 0, 0, 0);
        step();
        id(1, 11, 1, 0, 10, 0, 0);
        hif.flush = 1;
        #1;
        chk("fl_hazard", int'(hif.hazard), 0);
        step();
        hif.flush = 0;
        chk("fl_exe_bubble", int'(hif.EXE_WB_en), 0);
        chk("fl_mem_dest", int'(hif.MEM_Dest), 10);
        chk("fl_cnt", int'(hif.stall_cnt), 4);
        drain();

        // Reset in the middle of a stall
        id(1, 5, 1, 1, 0, 0, 0);
        step();
        id(1, 6, 1, 0, 0, 5, 1);
        chk("rs_hazard_pre", int'(hif.hazard), 1);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("rs_hazard", int'(hif.hazard), 0);
        chk("rs_exe_wb", int'(hif.EXE_WB_en), 0);
        chk("rs_cnt", int'(hif.stall_cnt), 0);
        drain();

        // Saturation on the 4-bit counter: self-dependent instruction held in
        // ID stalls 2 of every 3 cycles with forwarding off.
        sif.ID_valid = 1; sif.ID_Dest = 4'd1; sif.ID_WB_en = 1; sif.src1 = 4'd1;
        repeat (3) step();
        chk("sat_early", int'(sif.stall_cnt), 2);
        repeat (27) step();
        chk("sat_hold", int'(sif.stall_cnt), 15);
        sif.ID_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer side of the forwarding path: tracks destination tags of in-flight instructions through EXE, MEM and WB.
- Drives the MEM_Dest/MEM_WB_en and WB_Dest/WB_WB_en tag inputs consumed by operand forwarding.
- Asserts hazard when ID must stall because forwarding cannot resolve a dependency: load-use, or any RAW when forwarding is disabled.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_W, 4, register index width (16 architectural registers)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- freeze  in  1  memory-wait stall; holds all tracked stages
- flush  in  1  taken branch; kills the instruction currently in ID
- fwd_en  in  1  forwarding enabled
- ID_valid  in  1  ID holds a real instruction
- ID_Dest  in  REG_W  destination of ID instruction
- ID_WB_en  in  1  ID instruction writes the register file
- ID_MEM_R_en  in  1  ID instruction is a load
- src1  in  REG_W  first source register of ID
- src2  in  REG_W  second source register of ID
- two_src  in  1  src2 is actually read
- EXE_Dest, MEM_Dest, WB_Dest  out  REG_W  destination tags per stage
- EXE_WB_en, MEM_WB_en, WB_WB_en  out  1  stage holds a valid write
- hazard  out  1  stall IF/ID and insert bubble
- stall_cnt  out  CNT_W  hazard-cycle counter

Behaviour:
- Per-stage state: valid, Dest, WB_en, MEM_R_en for EXE, MEM and WB. Each stage WB_en output = valid & WB_en.
- Reset (rst_n=0 at clk edge): all valid=0, all Dest=0, stall_cnt=0. Outputs then read 0 and hazard=0 (combinational on cleared state).
- Advance rule, evaluated each edge when rst_n=1:
  - freeze=1: all stages hold; stall_cnt holds; flush is ignored.
  - freeze=0: WB<=MEM, MEM<=EXE.
  - freeze=0, EXE load: EXE<=bubble (valid=0, Dest=0) if hazard|flush|~ID_valid; otherwise EXE<={1, ID_Dest, ID_WB_en, ID_MEM_R_en}.
- Match condition: m(x, S) = S.valid & S.WB_en & (x==S.Dest). Applied to src1 always; to src2 only when two_src=1.
- hazard (combinational, 0 cycle latency):
  - forced 0 if ~ID_valid or flush.
  - fwd_en=1: 1 iff EXE.MEM_R_en & (m(src1,EXE) | two_src & m(src2,EXE)). Load-use only; MEM and WB matches are covered by forwarding.
  - fwd_en=0: 1 iff any match against EXE or MEM.
  - WB never causes hazard: the register file writes in first half-cycle.
  - hazard is asserted regardless of freeze; the stall simply persists.
- A stalled ID instruction re-evaluates each cycle. The load drains EXE->MEM after one non-frozen cycle, then hazard drops (fwd_en=1).
- stall_cnt increments by 1 on each edge with freeze=0 & hazard=1; saturates at all-ones, no wrap.
- Dest tags of invalid stages drive 0. Consumers qualify tags only with the WB_en outputs.
- Simultaneous flush & hazard: flush wins; bubble is inserted, hazard=0, counter does not increment.
- Reset mid-stall: next cycle all stages are empty and hazard=0.
- Implemented as ~150-250 lines: three stage registers, match logic, counter.

Test Plan:
- Reset: rst_n=0 two cycles with ID_valid=1 -> all *_WB_en=0, all Dest=0, stall_cnt=0, hazard=0.
- Tag pipeline: ALU op dest=3 issued, freeze=0 -> EXE_Dest=3/EXE_WB_en=1 at cycle 1, MEM at cycle 2, WB at cycle 3, all WB_en=0 at cycle 4.
- Load-use, fwd_en=1: load dest=5, then ID src1=5 -> hazard=1 for one cycle, EXE bubble, stall_cnt=1. Next cycle MEM_Dest=5, hazard=0, dependent enters EXE.
- No forwarding, fwd_en=0: ALU dest=2 then ID src2=2 with two_src=1 -> hazard=1 for 2 cycles, stall_cnt=2. With two_src=0 -> hazard=0.
- Freeze: load dest=7 in EXE, dependent in ID, freeze=1 for 4 cycles -> stages hold, hazard=1, stall_cnt unchanged. After release, count +1 then hazard=0.
- Flush priority: hazard condition present plus flush=1 -> hazard=0, EXE becomes a bubble next cycle, stall_cnt unchanged. Saturation: preload 0xFFFF, one more stall -> stays 0xFFFF.
